// File: rtl/jelly_mipi_rx_packet_parse_pkg.sv
// rtl/jelly_mipi_rx_packet_parse_pkg.sv - shared constants, state encoding and keep helper for the CSI-2 packet parser
//
// Purpose : constants and helpers shared by the CSI-2 RX packet parser.
// Contents: short-packet data-type threshold, header byte offsets,
//           parser state encoding, and keep_mask() which turns
//           min(lanes, remaining) into a per-lane byte-valid mask.

package jelly_mipi_rx_packet_parse_pkg;

  // Data types below this value (DI[5:0]) are short packets.
  localparam logic [5:0] DT_SHORT_MAX = 6'h10;

  // Byte offsets inside the 4-byte packet header.
  localparam int HDR_DI    = 0;
  localparam int HDR_WC_L  = 1;
  localparam int HDR_WC_H  = 2;
  localparam int HDR_ECC   = 3;
  localparam int HDR_BYTES = 4;

  // Long packets are followed by a 16-bit CRC.
  localparam int CRC_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CRC,
    ST_WAIT_END
  } state_t;

  // Mask with the low min(lanes, remaining) bits set (lanes <= 4).
  function automatic logic [3:0] keep_mask(input int lanes, input logic [15:0] remaining);
    logic [4:0] mask;
    int         n;
    n    = (remaining < 16'(lanes)) ? int'(remaining) : lanes;
    mask = (5'd1 << n) - 5'd1;
    return mask[3:0];
  endfunction

endpackage

// File: rtl/jelly_mipi_rx_packet_parse.sv
// rtl/jelly_mipi_rx_packet_parse.sv - CSI-2 packet header/payload parser for lane-aligned D-PHY HS bytes
//
// Purpose : finds the CSI-2 packet header in lane-aligned HS bytes, emits
//           it as a one-cycle record, then streams the long-packet payload
//           LANES bytes per beat. CRC and trailer bytes are dropped. No
//           backpressure: outputs are valid-only.
// Ports   :
//   clk, reset              byte clock, synchronous active-high reset
//   in_rxdatahs [LANES*8]   aligned HS bytes, lane k at [k*8+:8]
//   in_rxvalidhs[LANES]     per-lane valid (bit 0 used)
//   in_rxactivehs[LANES]    per-lane HS active (bit 0 used)
//   in_rxsynchs [LANES]     per-lane sync detected (bit 0 used)
//   header_valid            one-cycle pulse, header_* valid
//   header_di/wc/ecc        data identifier, word count, raw ECC
//   m_valid/m_data/m_keep   payload beat, lane-ordered bytes, byte mask
//   m_last                  final beat of a packet
//   m_error                 packet aborted (qualified by m_valid)

module jelly_mipi_rx_packet_parse
  import jelly_mipi_rx_packet_parse_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES*8-1:0] in_rxdatahs,
  input  logic [LANES-1:0]   in_rxvalidhs,
  input  logic [LANES-1:0]   in_rxactivehs,
  input  logic [LANES-1:0]   in_rxsynchs,
  output logic               header_valid,
  output logic [7:0]         header_di,
  output logic [15:0]        header_wc,
  output logic [7:0]         header_ecc,
  output logic               m_valid,
  output logic [LANES*8-1:0] m_data,
  output logic [LANES-1:0]   m_keep,
  output logic               m_last,
  output logic               m_error
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("jelly_mipi_rx_packet_parse: LANES must be 1, 2 or 4");
    end
  endgenerate

  localparam int HDR_BEATS = HDR_BYTES / LANES;

  logic valid0, active0, sync0;
  assign valid0  = in_rxvalidhs[0];
  assign active0 = in_rxactivehs[0];
  assign sync0   = in_rxsynchs[0];

  logic unused_lane_bits;
  assign unused_lane_bits = ^{in_rxvalidhs, in_rxactivehs, in_rxsynchs};

  state_t      state;
  logic [1:0]  hdr_cnt;
  logic [7:0]  hdr_buf [HDR_BYTES];
  logic [15:0] remaining;
  logic [1:0]  crc_left;

  logic        hdr_beat;
  logic        hdr_final;
  logic [1:0]  beat_idx;
  logic [7:0]  hdr_byte [HDR_BYTES];
  logic [15:0] hdr_wc;
  logic        hdr_short;
  logic        pay_last;
  logic [15:0] pay_step;
  logic [3:0]  pay_keep;
  int          tail;
  logic [1:0]  crc_after;
  logic [1:0]  crc_left_next;

  always_comb begin
    // The sync beat itself is header beat 0, so IDLE feeds the header path too.
    beat_idx  = (state == ST_IDLE) ? 2'd0 : hdr_cnt;
    hdr_beat  = valid0 && (((state == ST_IDLE) && sync0) ||
                           ((state == ST_HEADER) && active0));
    hdr_final = (int'(beat_idx) == HDR_BEATS - 1);

    // Merge bytes already collected with those arriving on this beat.
    for (int j = 0; j < HDR_BYTES; j++) begin
      if (j / LANES == int'(beat_idx)) hdr_byte[j] = in_rxdatahs[(j % LANES)*8 +: 8];
      else                             hdr_byte[j] = hdr_buf[j];
    end
    hdr_wc    = {hdr_byte[HDR_WC_H], hdr_byte[HDR_WC_L]};
    hdr_short = hdr_byte[HDR_DI][5:0] < DT_SHORT_MAX;

    pay_last  = remaining <= 16'(LANES);
    pay_step  = pay_last ? remaining : 16'(LANES);
    pay_keep  = keep_mask(LANES, remaining);

    // Lanes past the last payload byte on the final beat carry CRC bytes.
    tail      = pay_last ? LANES - int'(remaining) : 0;
    crc_after = (tail >= CRC_BYTES) ? 2'd0 : 2'(CRC_BYTES - tail);

    // A beat carries LANES CRC bytes; only LANES==1 can need a second beat.
    crc_left_next = (int'(crc_left) <= LANES) ? 2'd0 : crc_left - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      hdr_cnt      <= 2'd0;
      remaining    <= 16'd0;
      crc_left     <= 2'd0;
      for (int j = 0; j < HDR_BYTES; j++) hdr_buf[j] <= 8'd0;
      header_valid <= 1'b0;
      header_di    <= 8'd0;
      header_wc    <= 16'd0;
      header_ecc   <= 8'd0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_keep       <= '0;
      m_last       <= 1'b0;
      m_error      <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_error      <= 1'b0;

      case (state)
        ST_IDLE, ST_HEADER: begin
          if (state == ST_HEADER && !active0) begin
            state <= ST_IDLE;
          end else if (hdr_beat) begin
            for (int j = 0; j < HDR_BYTES; j++) hdr_buf[j] <= hdr_byte[j];
            hdr_cnt <= beat_idx + 2'd1;
            if (hdr_final) begin
              header_valid <= 1'b1;
              header_di    <= hdr_byte[HDR_DI];
              header_wc    <= hdr_wc;
              header_ecc   <= hdr_byte[HDR_ECC];
              remaining    <= hdr_wc;
              crc_left     <= 2'(CRC_BYTES);
              if (hdr_short)          state <= ST_WAIT_END;
              else if (hdr_wc == '0)  state <= ST_CRC;
              else                    state <= ST_PAYLOAD;
            end else begin
              state <= ST_HEADER;
            end
          end
        end

        ST_PAYLOAD: begin
          if (!active0) begin
            m_valid <= 1'b1;
            m_keep  <= '0;
            m_last  <= 1'b1;
            m_error <= 1'b1;
            state   <= ST_IDLE;
          end else if (valid0) begin
            m_valid   <= 1'b1;
            m_data    <= in_rxdatahs;
            m_keep    <= pay_keep[LANES-1:0];
            m_last    <= pay_last;
            remaining <= remaining - pay_step;
            if (pay_last) begin
              crc_left <= crc_after;
              state    <= (crc_after != 2'd0) ? ST_CRC : ST_WAIT_END;
            end
          end
        end

        ST_CRC: begin
          if (!active0) begin
            state <= ST_IDLE;
          end else if (valid0) begin
            crc_left <= crc_left_next;
            if (crc_left_next == 2'd0) state <= ST_WAIT_END;
          end
        end

        ST_WAIT_END: begin
          if (!active0) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jelly_mipi_rx_packet_parse.sv
// tb/tb_jelly_mipi_rx_packet_parse.sv - self-checking bench for jelly_mipi_rx_packet_parse at LANES=1,2,4

module tb_jelly_mipi_rx_packet_parse;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance index i has 1<<i lanes.
  logic [31:0] d_in [3];
  logic        v_in [3];
  logic        a_in [3];
  logic        s_in [3];

  logic        hv   [3];
  logic [7:0]  hdi  [3];
  logic [15:0] hwc  [3];
  logic [7:0]  hecc [3];
  logic        mv   [3];
  logic        ml   [3];
  logic        me   [3];
  logic [31:0] md   [3];
  logic [3:0]  mk   [3];

  logic [7:0]  od1;
  logic [15:0] od2;
  logic [31:0] od4;
  logic [0:0]  ok1;
  logic [1:0]  ok2;
  logic [3:0]  ok4;

  assign md[0] = {24'd0, od1};
  assign md[1] = {16'd0, od2};
  assign md[2] = od4;
  assign mk[0] = {3'd0, ok1};
  assign mk[1] = {2'd0, ok2};
  assign mk[2] = ok4;

  jelly_mipi_rx_packet_parse #(.LANES(1)) u_l1 (
    .clk(clk), .reset(reset),
    .in_rxdatahs(d_in[0][7:0]), .in_rxvalidhs(v_in[0]),
    .in_rxactivehs(a_in[0]), .in_rxsynchs(s_in[0]),
    .header_valid(hv[0]), .header_di(hdi[0]), .header_wc(hwc[0]), .header_ecc(hecc[0]),
    .m_valid(mv[0]), .m_data(od1), .m_keep(ok1), .m_last(ml[0]), .m_error(me[0])
  );

  jelly_mipi_rx_packet_parse #(.LANES(2)) u_l2 (
    .clk(clk), .reset(reset),
    .in_rxdatahs(d_in[1][15:0]), .in_rxvalidhs({2{v_in[1]}}),
    .in_rxactivehs({2{a_in[1]}}), .in_rxsynchs({2{s_in[1]}}),
    .header_valid(hv[1]), .header_di(hdi[1]), .header_wc(hwc[1]), .header_ecc(hecc[1]),
    .m_valid(mv[1]), .m_data(od2), .m_keep(ok2), .m_last(ml[1]), .m_error(me[1])
  );

  jelly_mipi_rx_packet_parse #(.LANES(4)) u_l4 (
    .clk(clk), .reset(reset),
    .in_rxdatahs(d_in[2]), .in_rxvalidhs({4{v_in[2]}}),
    .in_rxactivehs({4{a_in[2]}}), .in_rxsynchs({4{s_in[2]}}),
    .header_valid(hv[2]), .header_di(hdi[2]), .header_wc(hwc[2]), .header_ecc(hecc[2]),
    .m_valid(mv[2]), .m_data(od4), .m_keep(ok4), .m_last(ml[2]), .m_error(me[2])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string nm(input string s, input int i);
    return $sformatf("%s_L%0d", s, 1 << i);
  endfunction

  // Expected output events, stamped with the cycle they must appear in.
  typedef struct {
    int          inst;
    int          t;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } hrec_t;

  typedef struct {
    int          inst;
    int          t;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
  } prec_t;

  hrec_t hq[$];
  prec_t pq[$];

  logic        checking = 1'b0;
  int          hcnt [3];
  int          pcnt [3];
  int          ecnt [3];
  logic [7:0]  last_di   [3];
  logic [15:0] last_wc   [3];
  logic [3:0]  last_keep [3];
  logic        last_last [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      hcnt[i] = 0; pcnt[i] = 0; ecnt[i] = 0;
      last_di[i] = 0; last_wc[i] = 0; last_keep[i] = 0; last_last[i] = 0;
    end
  end

  // Compare process: every cycle, every instance, against the model queues.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        int hi;
        int pi;
        logic [31:0] msk;
        hi = -1;
        pi = -1;
        foreach (hq[k]) if (hq[k].inst == i && hq[k].t == cyc) hi = k;
        foreach (pq[k]) if (pq[k].inst == i && pq[k].t == cyc) pi = k;

        if (hi >= 0) begin
          chk(nm("header_valid", i), 64'(hv[i]), 64'd1);
          if (hv[i]) begin
            chk(nm("header_di", i),  64'(hdi[i]),  64'(hq[hi].di));
            chk(nm("header_wc", i),  64'(hwc[i]),  64'(hq[hi].wc));
            chk(nm("header_ecc", i), 64'(hecc[i]), 64'(hq[hi].ecc));
          end
          hq.delete(hi);
        end else begin
          chk(nm("header_valid_idle", i), 64'(hv[i]), 64'd0);
        end

        if (pi >= 0) begin
          chk(nm("m_valid", i), 64'(mv[i]), 64'd1);
          if (mv[i]) begin
            msk = 32'd0;
            for (int b = 0; b < 4; b++) if (pq[pi].keep[b]) msk[b*8 +: 8] = 8'hFF;
            chk(nm("m_keep", i),  64'(mk[i]), 64'(pq[pi].keep));
            chk(nm("m_last", i),  64'(ml[i]), 64'(pq[pi].last));
            chk(nm("m_error", i), 64'(me[i]), 64'(pq[pi].err));
            chk(nm("m_data", i),  64'(md[i] & msk), 64'(pq[pi].data & msk));
          end
          pq.delete(pi);
        end else begin
          chk(nm("m_valid_idle", i), 64'(mv[i]), 64'd0);
        end

        if (hv[i]) begin
          hcnt[i]    <= hcnt[i] + 1;
          last_di[i] <= hdi[i];
          last_wc[i] <= hwc[i];
        end
        if (mv[i]) begin
          pcnt[i]      <= pcnt[i] + 1;
          last_keep[i] <= mk[i];
          last_last[i] <= ml[i];
          if (me[i]) ecnt[i] <= ecnt[i] + 1;
        end
      end
    end
  end

  task automatic drive(input int i, input logic [31:0] d, input logic v, input logic a,
                       input logic s, output int t);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      d_in[k] = 32'd0; v_in[k] = 1'b0; a_in[k] = 1'b0; s_in[k] = 1'b0;
    end
    d_in[i] = d; v_in[i] = v; a_in[i] = a; s_in[i] = s;
    t = cyc;
  endtask

  // Sends one packet to instance i and records what the outputs must be.
  // gap_b: an invalid beat is inserted before beat gap_b.
  // ab_b/ab_kind: at beat ab_b, kind 1 drops activity, kind 2 pulses reset.
  // sync2_b: sync is also raised on that beat.
  task automatic send(input int i, input logic [7:0] di, input logic [15:0] wc,
                      input int gap_b, input int ab_b, input int ab_kind, input int sync2_b);
    int          lanes;
    int          hb;
    int          npb;
    int          nbeats;
    int          t;
    int          rem;
    int          m;
    bit          is_long;
    logic [7:0]  pk[$];
    logic [31:0] d;
    prec_t       pr;
    hrec_t       hr;

    lanes   = 1 << i;
    hb      = 4 / lanes - 1;
    is_long = di[5:0] >= 6'h10;
    npb     = (is_long && wc != 0) ? (int'(wc) + lanes - 1) / lanes : 0;

    pk.push_back(di);
    pk.push_back(wc[7:0]);
    pk.push_back(wc[15:8]);
    pk.push_back(di ^ 8'h5A);
    if (is_long) begin
      for (int j = 0; j < int'(wc); j++) pk.push_back(8'($urandom));
      pk.push_back(8'hC0);
      pk.push_back(8'hC1);
    end
    while (pk.size() % lanes != 0) pk.push_back(8'hEE);
    nbeats = pk.size() / lanes;

    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_b) drive(i, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, t);
      if (b == ab_b) begin
        if (ab_kind == 1) begin
          drive(i, 32'd0, 1'b0, 1'b0, 1'b0, t);
          if (b > hb && b <= hb + npb) begin
            pr.inst = i; pr.t = t + 1; pr.data = 32'd0; pr.keep = 4'd0;
            pr.last = 1'b1; pr.err = 1'b1;
            pq.push_back(pr);
          end
        end else begin
          drive(i, 32'd0, 1'b0, 1'b0, 1'b0, t);
          reset = 1'b1;
          @(negedge clk);
          @(negedge clk);
          chk(nm("rst_header_valid", i), 64'(hv[i]), 64'd0);
          chk(nm("rst_header_di", i),    64'(hdi[i]), 64'd0);
          chk(nm("rst_header_wc", i),    64'(hwc[i]), 64'd0);
          chk(nm("rst_header_ecc", i),   64'(hecc[i]), 64'd0);
          chk(nm("rst_m_valid", i),      64'(mv[i]), 64'd0);
          chk(nm("rst_m_last", i),       64'(ml[i]), 64'd0);
          chk(nm("rst_m_error", i),      64'(me[i]), 64'd0);
          chk(nm("rst_m_keep", i),       64'(mk[i]), 64'd0);
          chk(nm("rst_m_data", i),       64'(md[i]), 64'd0);
          @(posedge clk);
          #1;
          reset = 1'b0;
        end
        break;
      end

      d = 32'd0;
      for (int k = 0; k < lanes; k++) d[k*8 +: 8] = pk[b*lanes + k];
      drive(i, d, 1'b1, 1'b1, (b == 0 || b == sync2_b), t);

      if (b == hb) begin
        hr.inst = i; hr.t = t + 1; hr.di = di; hr.wc = wc; hr.ecc = pk[3];
        hq.push_back(hr);
      end
      if (b > hb && b <= hb + npb) begin
        rem = int'(wc) - (b - hb - 1) * lanes;
        m   = (rem < lanes) ? rem : lanes;
        pr.inst = i; pr.t = t + 1; pr.data = d;
        pr.keep = 4'((1 << m) - 1);
        pr.last = (rem <= lanes);
        pr.err  = 1'b0;
        pq.push_back(pr);
      end
    end

    for (int k = 0; k < 3; k++) drive(i, 32'd0, 1'b0, 1'b0, 1'b0, t);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int h0, p0, e0, t;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_in[k] = 32'd0; v_in[k] = 1'b0; a_in[k] = 1'b0; s_in[k] = 1'b0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk(nm("reset_header_valid", i), 64'(hv[i]), 64'd0);
      chk(nm("reset_m_valid", i),      64'(mv[i]), 64'd0);
      chk(nm("reset_m_keep", i),       64'(mk[i]), 64'd0);
      chk(nm("reset_header_wc", i),    64'(hwc[i]), 64'd0);
      chk(nm("reset_m_data", i),       64'(md[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1'b1;
    drive(0, 32'd0, 1'b0, 1'b0, 1'b0, t);

    // LANES=4 short packet DI=00 WC=0001
    h0 = hcnt[2]; p0 = pcnt[2];
    send(2, 8'h00, 16'h0001, -1, -1, 0, -1);
    chk("t1_hdr_count", 64'(hcnt[2] - h0), 64'd1);
    chk("t1_wc", 64'(last_wc[2]), 64'h0001);
    chk("t1_no_payload", 64'(pcnt[2] - p0), 64'd0);

    // LANES=4 long DI=2A WC=5: keep 1111 then 0001 with last
    p0 = pcnt[2];
    send(2, 8'h2A, 16'd5, -1, -1, 0, -1);
    chk("t2_di", 64'(last_di[2]), 64'h2A);
    chk("t2_beats", 64'(pcnt[2] - p0), 64'd2);
    chk("t2_last_keep", 64'(last_keep[2]), 64'h1);
    chk("t2_last_flag", 64'(last_last[2]), 64'd1);

    // LANES=4 boundary cases: WC equal to LANES, DT exactly 0x10, VC bits set on short DT
    send(2, 8'h2A, 16'd4, -1, -1, 0, -1);
    chk("t2b_keep", 64'(last_keep[2]), 64'hF);
    p0 = pcnt[2];
    send(2, 8'h10, 16'd3, -1, -1, 0, -1);
    chk("t2c_dt10_long", 64'(pcnt[2] - p0), 64'd1);
    p0 = pcnt[2];
    send(2, 8'h4F, 16'h1234, -1, -1, 0, -1);
    chk("t2d_short_vc", 64'(pcnt[2] - p0), 64'd0);
    chk("t2d_wc", 64'(last_wc[2]), 64'h1234);

    // LANES=2 long DI=2B WC=4
    p0 = pcnt[1];
    send(1, 8'h2B, 16'd4, -1, -1, 0, -1);
    chk("t3_beats", 64'(pcnt[1] - p0), 64'd2);
    chk("t3_last_keep", 64'(last_keep[1]), 64'h3);

    // LANES=1 DI=12 WC=0 with a second sync during CRC
    h0 = hcnt[0]; p0 = pcnt[0];
    send(0, 8'h12, 16'd0, -1, -1, 0, 4);
    chk("t4_hdr_count", 64'(hcnt[0] - h0), 64'd1);
    chk("t4_no_payload", 64'(pcnt[0] - p0), 64'd0);
    send(0, 8'h2A, 16'd3, -1, -1, 0, -1);
    chk("t4b_keep", 64'(last_keep[0]), 64'h1);

    // LANES=2 WC=8 with activity drop after 2 payload beats
    e0 = ecnt[1]; p0 = pcnt[1];
    send(1, 8'h2C, 16'd8, -1, 4, 1, -1);
    chk("t5_err_count", 64'(ecnt[1] - e0), 64'd1);
    chk("t5_beats", 64'(pcnt[1] - p0), 64'd3);
    chk("t5_err_keep", 64'(last_keep[1]), 64'h0);
    p0 = pcnt[1]; e0 = ecnt[1];
    send(1, 8'h2C, 16'd6, 3, -1, 0, -1);
    chk("t5b_beats", 64'(pcnt[1] - p0), 64'd3);
    chk("t5b_no_err", 64'(ecnt[1] - e0), 64'd0);

    // LANES=2 header aborted before completion produces nothing
    h0 = hcnt[1];
    send(1, 8'h2E, 16'd4, -1, 1, 1, -1);
    chk("t5c_hdr_abort", 64'(hcnt[1] - h0), 64'd0);

    // LANES=2 reset in PAYLOAD, then a clean packet
    send(1, 8'h2D, 16'd8, -1, 3, 2, -1);
    send(1, 8'h1E, 16'd2, -1, -1, 0, -1);
    chk("t6_di", 64'(last_di[1]), 64'h1E);
    chk("t6_wc", 64'(last_wc[1]), 64'd2);

    repeat (4) @(negedge clk);
    chk("pending_headers", 64'(hq.size()), 64'd0);
    chk("pending_payload", 64'(pq.size()), 64'd0);
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jelly_mipi_rx_packet_parse.md
Name: jelly_mipi_rx_packet_parse

Overview:
- Sits directly downstream of the lane-synchronising stage in the MIPI RX path.
- Consumes lane-aligned D-PHY HS bytes (LANES bytes per cycle) and finds the CSI-2 packet header (DI, WC, ECC).
- Emits the header as a one-cycle record, then the long-packet payload as a LANES-byte-wide stream with keep/last; CRC and trailer bytes are dropped.
- No backpressure: the PHY cannot stall, so outputs are valid-only.

Parameters:
- LANES, 2, number of data lanes; legal values 1, 2 or 4, any other value is an elaboration error.

Ports:
- clk  input  1  byte clock
- reset  input  1  synchronous active-high reset
- in_rxdatahs  input  LANES*8  aligned HS bytes; lane k occupies bits [k*8+:8]
- in_rxvalidhs  input  LANES  per-lane valid; only bit 0 is used
- in_rxactivehs  input  LANES  per-lane HS active; only bit 0 is used
- in_rxsynchs  input  LANES  per-lane sync-detected; only bit 0 is used
- header_valid  output  1  one-cycle pulse, header fields valid
- header_di  output  8  data identifier
- header_wc  output  16  word count (or short-packet data field)
- header_ecc  output  8  raw ECC byte; not checked here
- m_valid  output  1  payload beat valid
- m_data  output  LANES*8  payload bytes, lane order
- m_keep  output  LANES  per-byte valid mask
- m_last  output  1  final beat of the packet
- m_error  output  1  packet aborted; qualified by m_valid

Behaviour:
- A beat is an input cycle with in_rxvalidhs[0]=1. Packet byte n is on lane n%LANES of beat n/LANES.
- Header bytes, in order: DI, WC[7:0], WC[15:8], ECC. Header takes 4/LANES beats.
- Payload always starts on lane 0, so no byte realignment is needed.
- States:
  - IDLE: in_rxsynchs[0]&in_rxvalidhs[0] starts HEADER; that beat is header beat 0. Sync seen in any other state is ignored.
  - HEADER: collect header bytes. At the final header beat:
    - DI[5:0] < 6'h10 (short packet) -> WAIT_END.
    - Otherwise, WC==0 -> CRC.
    - Otherwise -> PAYLOAD.
  - PAYLOAD: remaining-byte counter (16 bit) loads WC, decrements by min(LANES, remaining) per beat.
    - Beat with remaining <= LANES: m_last=1; keep = low `remaining` bits set.
    - If remaining < LANES, the same beat also carries CRC bytes; track how many CRC bytes are consumed.
    - Exit to CRC when fewer than 2 CRC bytes have been consumed, else WAIT_END.
  - CRC: consume the remaining CRC bytes (0..2) on valid beats, then WAIT_END.
  - WAIT_END: wait for in_rxactivehs[0]=0, then IDLE.
- Activity drop: in_rxactivehs[0]=0 in HEADER, PAYLOAD or CRC is treated as an abort.
  - In PAYLOAD, emit one beat: m_valid=1, m_keep=0, m_last=1, m_error=1.
  - In HEADER, no header_valid is produced.
  - In all cases go to IDLE. m_error=0 on all other beats.
- Invalid beats (valid=0 while active=1) advance nothing and produce no output.
- Timing:
  - header_valid asserts 1 cycle after the final header beat.
  - Each payload beat appears 1 cycle after its input beat.
  - header_valid and the first payload beat are never in the same cycle.
  - header_* fields hold their value until the next header.
- m_data bytes where keep=0 are don't-care.
- Reset values: state IDLE, counters 0; header_valid, m_valid, m_last, m_error = 0; m_keep = 0; header_* and m_data = 0.
- Reset mid-packet discards the packet with no output.

Decomposition:
- Shared package holds:
  - DT short-packet threshold 6'h10
  - Header byte-offset constants (DI=0, WC_L=1, WC_H=2, ECC=3)
  - State encoding IDLE/HEADER/PAYLOAD/CRC/WAIT_END
  - A function min(LANES, remaining) -> keep mask
- No sub-module; a single flat module is the natural structure.

Test Plan:
- LANES=4, short packet bytes {00,01,00,XX} on sync beat -> header_valid one cycle later, DI=00, WC=0001; no m_valid.
- LANES=4, long DI=2A WC=5 -> header; beat1 keep=1111 last=0; beat2 keep=0001 last=1 (CRC occupies lanes 1-2); IDLE after activehs drops.
- LANES=2, DI=2B WC=4 -> header after 2 beats; payload beats keep=11,11, last on 2nd; CRC state consumes 1 beat.
- LANES=1, DI=12 WC=0 -> header after 4 beats; no payload; 2 CRC beats consumed; second sync during CRC ignored.
- LANES=2, WC=8, activehs drops after 2 payload beats -> error beat keep=00 last=1 error=1; next packet parses cleanly.
- Reset asserted in PAYLOAD -> all outputs 0 the next cycle; following packet's header is parsed correctly.
